// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: round-robin arbiter that picks one 16-bit immediate per cycle
// and returns it extended to 32 bits through a single-entry output register.
// Build option: define IMM_ZEXT_EN to let ReqZero select zero-extension per requester.
module imm_ext_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [NREQ-1:0]      ReqValid,
  input  logic [16*NREQ-1:0]   ReqImm,
  input  logic [NREQ-1:0]      ReqZero,
  output logic [NREQ-1:0]      ReqReady,
  output logic                 OutValid,
  output logic [31:0]          OutData,
  output logic [IDW-1:0]       OutId,
  input  logic                 OutReady
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e         state_q, state_d;
  logic [31:0]    data_q, data_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] last_q, last_d;

  logic           accept;
  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] cand;
  logic           transfer;
  logic [15:0]    grant_imm;
  logic           grant_zero;
  logic [31:0]    grant_ext;

  // The output slot can take a new result when empty or when it drains this cycle.
  assign accept   = (state_q == StEmpty) || OutReady;
  assign transfer = accept && grant_found;

  // Round-robin search starting just after the last granted requester.
  // NREQ is a power of two, so IDW-bit wrap-around is the modulo.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = last_q + IDW'(k);
      if (!grant_found && ReqValid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // One-hot ready for the winner; held low throughout reset.
  always_comb begin
    ReqReady = '0;
    if (Rst_n && transfer) begin
      ReqReady[grant_id] = 1'b1;
    end
  end

  assign grant_imm = ReqImm[{grant_id, 4'b0000} +: 16];

`ifdef IMM_ZEXT_EN
  assign grant_zero = ReqZero[grant_id];
`else
  logic unused_req_zero;
  assign unused_req_zero = ^ReqZero;
  assign grant_zero      = 1'b0;
`endif

  assign grant_ext = grant_zero ? {16'h0000, grant_imm} : {{16{grant_imm[15]}}, grant_imm};

  // Output-stage FSM: a transfer always fills; a drain without refill empties.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (transfer) state_d = StFull;
      StFull: begin
        if (transfer) begin
          state_d = StFull;
        end else if (OutReady) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Datapath next state: load result, owner and round-robin pointer on a transfer.
  always_comb begin
    data_d = data_q;
    id_d   = id_q;
    last_d = last_q;
    if (transfer) begin
      data_d = grant_ext;
      id_d   = grant_id;
      last_d = grant_id;
    end
  end

  // State registers; reset points Last at NREQ-1 so requester 0 wins first.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StEmpty;
      data_q  <= '0;
      id_q    <= '0;
      last_q  <= IDW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign OutValid = (state_q == StFull);
  assign OutData  = data_q;
  assign OutId    = id_q;

endmodule
